switch_alloc: RTL and testbench

- Router-level output-channel allocator for the BiNoC router.
- Collects the `channel_req` vectors from all ten port instances and arbitrates each output channel among the requesting input ports.
- Returns a registered one-hot `channel_gnt` per port, and the `sel` code each output port's mux uses to pick its source.
- Holds each allocation (wormhole lock) until the owner's request drops. Reports channel occupancy to the channel-direction logic.

---
 rtl/noc_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/switch_alloc.sv | 177 +++++++++++++++++
 tb/tb_switch_alloc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, select width, port index type
// and the per-output allocation state encoding.
package noc_pkg;

  localparam int NUM_PORTS = 10;
  localparam int SEL_W     = 4;

  typedef logic [SEL_W-1:0] port_idx_t;

  // Index of the first router port; also the select value shown by an idle output.
  localparam port_idx_t PORT_FIRST = 4'd0;

  // Per-output allocation state: IDLE (free) or HELD (wormhole-locked to an owner).
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, searching upward with wrap-around. Purely combinational.
module rr_arbiter #(
  parameter int N = noc_pkg::NUM_PORTS,
  parameter int W = noc_pkg::SEL_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  // Scan requesters starting at the pointer and grant the first one found.
  always_comb begin
    logic [W:0] cand;
    logic       found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (W+1)'(k);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end else begin
        cand = cand;
      end
      if (en && !found && req[cand[W-1:0]]) begin
        gnt[cand[W-1:0]] = 1'b1;
        idx              = cand[W-1:0];
        found            = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// Router-level output-channel allocator. Each output channel is arbitrated
// round-robin among eligible requesting inputs and then wormhole-locked to
// its owner until that owner's request drops. An input may own at most one
// output; conflicts among idle outputs resolve in ascending output order.
module switch_alloc #(
  parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int SEL_W     = noc_pkg::SEL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req_flat,
  input  logic [NUM_PORTS-1:0]           out_mode,
  output logic [NUM_PORTS*NUM_PORTS-1:0] gnt_flat,
  output logic [NUM_PORTS*SEL_W-1:0]     sel_flat,
  output logic [NUM_PORTS-1:0]           sel_valid,
  output logic [NUM_PORTS-1:0]           out_busy
);

  import noc_pkg::*;

  alloc_state_t         state_r   [NUM_PORTS];
  alloc_state_t         state_nxt [NUM_PORTS];
  logic [SEL_W-1:0]     owner_r   [NUM_PORTS];
  logic [SEL_W-1:0]     owner_nxt [NUM_PORTS];
  logic [SEL_W-1:0]     rr_r      [NUM_PORTS];
  logic [SEL_W-1:0]     rr_nxt    [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_col   [NUM_PORTS];
  logic [NUM_PORTS-1:0] owned_s;
  logic [NUM_PORTS-1:0] win_any_s;
  logic [SEL_W-1:0]     win_idx_s [NUM_PORTS];

  logic [NUM_PORTS*NUM_PORTS-1:0] gnt_nxt;
  logic [NUM_PORTS*SEL_W-1:0]     sel_nxt;
  logic [NUM_PORTS-1:0]           lock_nxt;

  // Transpose the flat request matrix into one requester column per output.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      req_col[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req_col[j][i] = req_flat[i*NUM_PORTS+j];
      end
    end
  end

  // Inputs that currently own an output are ineligible for every other output.
  always_comb begin
    owned_s = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (state_r[j] == ST_HELD) begin
        owned_s[owner_r[j]] = 1'b1;
      end else begin
        owned_s = owned_s;
      end
    end
  end

  // One arbiter per output; each output masks out inputs already taken by
  // held outputs or won by a lower-indexed idle output this cycle.
  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    logic [NUM_PORTS-1:0] busy_before;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [SEL_W-1:0]     idx;

    if (j == 0) begin : g_first
      assign busy_before = owned_s;
    end else begin : g_chain
      assign busy_before = g_out[j-1].busy_before | g_out[j-1].grant_vec;
    end

    assign elig = req_col[j] & ~busy_before & {NUM_PORTS{out_mode[j]}};

    rr_arbiter #(
      .N (NUM_PORTS),
      .W (SEL_W)
    ) u_arb (
      .req (elig),
      .ptr (rr_r[j]),
      .en  (state_r[j] == ST_IDLE),
      .gnt (grant_vec),
      .idx (idx)
    );

    assign win_any_s[j] = |grant_vec;
    assign win_idx_s[j] = idx;
  end

  // Next-state logic: IDLE locks onto the arbiter winner, HELD releases when
  // the owner drops its request (no re-arbitration in the release cycle).
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      state_nxt[j] = state_r[j];
      owner_nxt[j] = owner_r[j];
      rr_nxt[j]    = rr_r[j];
      case (state_r[j])
        ST_IDLE: begin
          if (win_any_s[j]) begin
            state_nxt[j] = ST_HELD;
            owner_nxt[j] = win_idx_s[j];
            if (win_idx_s[j] == SEL_W'(NUM_PORTS-1)) begin
              rr_nxt[j] = PORT_FIRST;
            end else begin
              rr_nxt[j] = win_idx_s[j] + SEL_W'(1);
            end
          end else begin
            state_nxt[j] = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!req_col[j][owner_r[j]]) begin
            state_nxt[j] = ST_IDLE;
            owner_nxt[j] = PORT_FIRST;
          end else begin
            state_nxt[j] = ST_HELD;
          end
        end
        default: begin
          state_nxt[j] = ST_IDLE;
          owner_nxt[j] = PORT_FIRST;
        end
      endcase
    end
  end

  // Output decode from next state so grant, select and busy are registered.
  always_comb begin
    gnt_nxt  = '0;
    sel_nxt  = '0;
    lock_nxt = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      lock_nxt[j] = (state_nxt[j] == ST_HELD);
      if (lock_nxt[j]) begin
        sel_nxt[j*SEL_W +: SEL_W] = owner_nxt[j];
        for (int i = 0; i < NUM_PORTS; i++) begin
          gnt_nxt[i*NUM_PORTS+j] = (owner_nxt[j] == SEL_W'(i));
        end
      end else begin
        sel_nxt[j*SEL_W +: SEL_W] = PORT_FIRST;
      end
    end
  end

  // Per-output state register: lock state, owner and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_r[j] <= ST_IDLE;
        owner_r[j] <= PORT_FIRST;
        rr_r[j]    <= PORT_FIRST;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_r[j] <= state_nxt[j];
        owner_r[j] <= owner_nxt[j];
        rr_r[j]    <= rr_nxt[j];
      end
    end
  end

  // Output register: grants, mux selects and occupancy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_flat  <= '0;
      sel_flat  <= '0;
      sel_valid <= '0;
      out_busy  <= '0;
    end else begin
      gnt_flat  <= gnt_nxt;
      sel_flat  <= sel_nxt;
      sel_valid <= lock_nxt;
      out_busy  <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_switch_alloc.sv
// Directed self-checking bench for switch_alloc.
module tb_switch_alloc;

  localparam int N = 10;
  localparam int W = 4;

  logic             clk;
  logic             rst;
  logic [N*N-1:0]   req_flat;
  logic [N-1:0]     out_mode;
  logic [N*N-1:0]   gnt_flat;
  logic [N*W-1:0]   sel_flat;
  logic [N-1:0]     sel_valid;
  logic [N-1:0]     out_busy;

  int checks;
  int errors;

  switch_alloc #(.NUM_PORTS(N), .SEL_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_flat  (req_flat),
    .out_mode  (out_mode),
    .gnt_flat  (gnt_flat),
    .sel_flat  (sel_flat),
    .sel_valid (sel_valid),
    .out_busy  (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    req_flat = '0;
    out_mode = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (gnt_flat !== '0) begin
      errors++; $display("FAIL reset_gnt: got %h expected 0", gnt_flat);
    end
    checks++;
    if (sel_flat !== '0) begin
      errors++; $display("FAIL reset_sel: got %h expected 0", sel_flat);
    end
    checks++;
    if (sel_valid !== '0) begin
      errors++; $display("FAIL reset_sel_valid: got %b expected 0", sel_valid);
    end
    checks++;
    if (out_busy !== '0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", out_busy);
    end
  endtask

  task automatic test_single();
    logic [N*N-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[2*N+5] = 1'b1;
    apply_reset();
    req_flat[2*N+5] = 1'b1;
    step();
    checks++;
    if (gnt_flat !== exp_gnt) begin
      errors++; $display("FAIL single_gnt: got %h expected %h", gnt_flat, exp_gnt);
    end
    checks++;
    if (sel_flat[5*W +: W] !== 4'd2) begin
      errors++; $display("FAIL single_sel: got %0d expected 2", sel_flat[5*W +: W]);
    end
    checks++;
    if (out_busy !== 10'b00_0010_0000 || sel_valid !== 10'b00_0010_0000) begin
      errors++; $display("FAIL single_busy: got busy %b valid %b expected 0000100000", out_busy, sel_valid);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (gnt_flat !== exp_gnt) begin
        errors++; $display("FAIL single_hold cycle %0d: got %h expected %h", c, gnt_flat, exp_gnt);
      end
    end
    req_flat = '0;
    step();
    checks++;
    if (out_busy !== '0 || gnt_flat !== '0) begin
      errors++; $display("FAIL single_release: got busy %b gnt %h expected 0", out_busy, gnt_flat);
    end
  endtask

  task automatic test_round_robin();
    int exp_owner [13];
    exp_owner = '{1, 1, 1, -1, 4, 4, 4, -1, 7, 7, 7, -1, 1};
    apply_reset();
    req_flat[1*N+0] = 1'b1;
    req_flat[4*N+0] = 1'b1;
    req_flat[7*N+0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      checks++;
      if (exp_owner[k] < 0) begin
        if (sel_valid[0] !== 1'b0 || gnt_flat !== '0) begin
          errors++; $display("FAIL rr_idle cycle %0d: got valid %b gnt %h expected idle", k, sel_valid[0], gnt_flat);
        end
      end else begin
        if (sel_valid[0] !== 1'b1 || sel_flat[W-1:0] !== 4'(exp_owner[k]) || gnt_flat[exp_owner[k]*N] !== 1'b1) begin
          errors++; $display("FAIL rr_owner cycle %0d: got valid %b sel %0d expected owner %0d", k, sel_valid[0], sel_flat[W-1:0], exp_owner[k]);
        end
      end
      req_flat[1*N+0] = 1'b1;
      req_flat[4*N+0] = 1'b1;
      req_flat[7*N+0] = 1'b1;
      if (k < 12 && exp_owner[k] >= 0 && exp_owner[k+1] < 0) begin
        req_flat[exp_owner[k]*N+0] = 1'b0;
      end
    end
  endtask

  task automatic test_direction();
    apply_reset();
    out_mode[6] = 1'b0;
    req_flat[3*N+6] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_busy[6] !== 1'b0 || gnt_flat !== '0) begin
        errors++; $display("FAIL dir_blocked cycle %0d: got busy %b gnt %h expected none", c, out_busy[6], gnt_flat);
      end
    end
    out_mode[6] = 1'b1;
    step();
    checks++;
    if (gnt_flat[3*N+6] !== 1'b1 || sel_flat[6*W +: W] !== 4'd3) begin
      errors++; $display("FAIL dir_open: got gnt %b sel %0d expected 1 and 3", gnt_flat[3*N+6], sel_flat[6*W +: W]);
    end
  endtask

  task automatic test_one_grant();
    logic [N*N-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[0*N+2] = 1'b1;
    exp_gnt[9*N+8] = 1'b1;
    apply_reset();
    req_flat[0*N+2] = 1'b1;
    req_flat[0*N+8] = 1'b1;
    req_flat[9*N+8] = 1'b1;
    step();
    checks++;
    if (gnt_flat[0*N+8] !== 1'b0) begin
      errors++; $display("FAIL one_grant_dup: got gnt[0][8]=%b expected 0", gnt_flat[0*N+8]);
    end
    checks++;
    if (gnt_flat !== exp_gnt) begin
      errors++; $display("FAIL one_grant_map: got %h expected %h", gnt_flat, exp_gnt);
    end
    checks++;
    if (sel_flat[8*W +: W] !== 4'd9 || out_busy !== 10'b01_0000_0100) begin
      errors++; $display("FAIL one_grant_sel: got sel8 %0d busy %b expected 9 and 0100000100", sel_flat[8*W +: W], out_busy);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    req_flat[9*N+3] = 1'b1;
    step();
    checks++;
    if (sel_valid[3] !== 1'b1 || sel_flat[3*W +: W] !== 4'd9) begin
      errors++; $display("FAIL wrap_first: got valid %b sel %0d expected 1 and 9", sel_valid[3], sel_flat[3*W +: W]);
    end
    req_flat = '0;
    req_flat[0*N+3] = 1'b1;
    req_flat[8*N+3] = 1'b1;
    step();
    checks++;
    if (sel_valid[3] !== 1'b0) begin
      errors++; $display("FAIL wrap_idle: got valid %b expected 0", sel_valid[3]);
    end
    step();
    checks++;
    if (sel_valid[3] !== 1'b1 || sel_flat[3*W +: W] !== 4'd0 || gnt_flat[0*N+3] !== 1'b1) begin
      errors++; $display("FAIL wrap_next: got valid %b sel %0d expected 1 and 0", sel_valid[3], sel_flat[3*W +: W]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_flat[4*N+0] = 1'b1;
    req_flat[5*N+1] = 1'b1;
    req_flat[6*N+2] = 1'b1;
    step();
    checks++;
    if (out_busy !== 10'b00_0000_0111) begin
      errors++; $display("FAIL areset_held: got busy %b expected 0000000111", out_busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (gnt_flat !== '0 || sel_valid !== '0 || out_busy !== '0 || sel_flat !== '0) begin
      errors++; $display("FAIL areset_clear: got gnt %h valid %b busy %b expected all 0", gnt_flat, sel_valid, out_busy);
    end
    req_flat = '0;
    req_flat[3*N+0] = 1'b1;
    req_flat[7*N+0] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_flat !== '0 || out_busy !== '0) begin
      errors++; $display("FAIL areset_hold: got gnt %h busy %b expected 0", gnt_flat, out_busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if (sel_valid[0] !== 1'b1 || sel_flat[W-1:0] !== 4'd3 || gnt_flat[3*N+0] !== 1'b1) begin
      errors++; $display("FAIL areset_after: got valid %b sel %0d expected 1 and 3", sel_valid[0], sel_flat[W-1:0]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    req_flat = '0;
    out_mode = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_direction();
    test_one_grant();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
